ps2_scan_decoder: RTL and testbench
===================================

Name: ps2_scan_decoder

Overview:
- Sits directly downstream of the PS/2 keyboard receiver.
- Consumes the receiver's one-cycle byte-done strobe and 8-bit scancode, and assembles Set-2 prefix sequences (E0 extended, F0 break) into single key events.
- Tracks Shift/Ctrl/Alt modifier state and buffers events in a small FIFO for the consumer (display/CPU logic).
- Drives the receiver's enable low to apply backpressure when the FIFO nears full.

Parameters:
- DEPTH, 8: event FIFO depth in entries; power of 2, minimum 4.
- TIMEOUT, 1_000_000: clk cycles a pending prefix may wait for its next byte before the FSM abandons it (10 ms at 100 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_done_tick  in  1  one-cycle strobe from receiver; byte valid on scan_in.
- scan_in  in  8  received scancode byte.
- rx_en  out  1  enable to receiver; high when the FIFO can accept another event.
- ev_rd  in  1  consumer pops head event; ignored when ev_empty.
- ev_data  out  10  head event {ext, brk, code[7:0]}; show-ahead, valid while ~ev_empty.
- ev_empty  out  1  FIFO empty.
- ev_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- shift_held  out  1  left or right Shift currently pressed.
- ctrl_held  out  1  left or right Ctrl currently pressed.
- alt_held  out  1  left or right Alt currently pressed.

Behaviour:
- Reset (async) values:
  - FSM = IDLE, timeout counter = 0.
  - FIFO pointers 0; ev_empty=1, ev_count=0, ev_data=0.
  - overflow=0, shift/ctrl/alt_held=0, rx_en=1.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Transitions occur only on cycles with rx_done_tick=1:
  - IDLE: byte E0 -> GOT_E0; byte F0 -> GOT_F0; any other byte -> emit {0,0,byte}, stay IDLE.
  - GOT_E0: byte F0 -> GOT_E0F0; byte E0 -> stay GOT_E0 (redundant prefix); other -> emit {1,0,byte}, go IDLE.
  - GOT_F0: byte F0 or E0 -> stay GOT_F0 (malformed; prefix retained); other -> emit {0,1,byte}, go IDLE.
  - GOT_E0F0: byte E0/F0 -> stay; other -> emit {1,1,byte}, go IDLE.
- Bytes E1, AA, FA, EE, FC are not special; they are emitted as ordinary codes.
- Timeout:
  - Counter clears on every rx_done_tick and whenever the FSM is in IDLE; it counts otherwise.
  - On reaching TIMEOUT-1 the FSM returns to IDLE with no emit.
- Emit latency: the event is written to the FIFO on the clk edge that samples rx_done_tick. ev_empty falls and ev_data is valid in the following cycle.
- Modifiers update on the same edge as the emit, independent of FIFO space:
  - code 12 or 59 sets/clears shift_held (make/break).
  - code 14, with or without ext, drives ctrl_held.
  - code 11, with or without ext, drives alt_held.
  - Left/right are OR'd via separate internal bits: releasing one Shift while the other is held keeps shift_held=1.
- FIFO:
  - Read pops the head on ev_rd & ~ev_empty.
  - Write when full with no simultaneous read: the event is dropped and overflow is set.
  - Full with simultaneous read and write: both proceed, count unchanged.
  - Empty with simultaneous write and ev_rd: ev_rd is ignored and the write lands.
  - Pointers wrap modulo DEPTH.
- rx_en = (ev_count < DEPTH-1), registered. The one slot of slack absorbs a frame already in flight when rx_en drops, since the receiver only gates frame start.
- Reset mid-sequence: a pending prefix is discarded and all modifiers are cleared.

Decomposition:
- Package ps2_pkg holds:
  - Constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59, SC_CTRL=8'h14, SC_ALT=8'h11.
  - The FSM state enum.
  - Event field positions: EV_EXT=9, EV_BRK=8.
- One sub-module, ps2_event_fifo: parameterised width/depth synchronous FIFO with show-ahead output, count, full/empty, drop-on-full with overflow flag.
- The FSM, timeout counter and modifier tracking stay in the top-level module.

Test Plan:
- Make/break: bytes 1C, F0, 1C -> two events, 0x01C then 0x11C; ev_count=2; modifiers unchanged.
- Extended release: bytes E0, F0, 75 -> single event 0x375; FSM back in IDLE; no event for the prefix bytes.
- Dual Shift: bytes 12, 59, F0, 12 -> shift_held 1,1,1 after each event; then F0, 59 -> shift_held=0.
- Prefix timeout (TIMEOUT=16): E0, idle 20 cycles, then 1C -> event 0x01C, not 0x21C.
- Backpressure/overflow (DEPTH=4):
  - Push 3 make codes with no reads -> rx_en=0 after the 3rd.
  - Force 2 more -> 4th is accepted, 5th dropped, overflow=1.
  - Drain 4 -> events appear in order; rx_en returns to 1.
- Simultaneous read/write at full plus async reset asserted mid-sequence after E0 -> count steady during read/write; after reset: ev_empty=1, overflow=0, FSM IDLE, next byte 1C yields 0x01C.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, event field positions and FSM state type for the PS/2
// Set-2 scancode decoder.
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;

  localparam int EV_EXT = 9;
  localparam int EV_BRK = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_E0   = 2'd1,
    ST_GOT_F0   = 2'd2,
    ST_GOT_E0F0 = 2'd3
  } ps2_state_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_EXT) || (b == SC_BRK);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO with show-ahead head, occupancy count and a sticky
// overflow flag raised when a write is dropped because the FIFO is full.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic             w_do_rd;
  logic             w_do_wr;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  // Empty FIFO shows zero rather than stale memory.
  assign o_rd_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  // A read on empty is ignored; a write when full only lands if a read frees a slot.
  assign w_do_rd = i_rd & ~o_empty;
  assign w_do_wr = i_wr & (~o_full | w_do_rd);

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_wr && !w_do_rd)      r_count <= r_count + 1'b1;
      else if (w_do_rd && !w_do_wr) r_count <= r_count - 1'b1;
      if (i_wr && !w_do_wr) r_overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// Assembles PS/2 Set-2 prefix sequences into {ext, brk, code} events, tracks
// modifier keys and buffers events, throttling the receiver as the FIFO fills.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_done_tick,
  input  logic [7:0]             scan_in,
  output logic                   rx_en,
  input  logic                   ev_rd,
  output logic [9:0]             ev_data,
  output logic                   ev_empty,
  output logic [$clog2(DEPTH):0] ev_count,
  output logic                   overflow,
  output logic                   shift_held,
  output logic                   ctrl_held,
  output logic                   alt_held,
  output ps2_state_t             dbg_state
);

  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam int CNW = $clog2(DEPTH) + 1;

  ps2_state_t r_state;
  ps2_state_t w_state_nx;
  logic [CW-1:0] r_tmo_cnt;
  logic       w_emit;
  logic [9:0] w_ev;
  logic       w_full;
  logic       w_make;
  logic       r_rx_en;
  logic       r_lshift, r_rshift, r_lctrl, r_rctrl, r_lalt, r_ralt;

  assign dbg_state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_emit     = 1'b0;
    w_ev       = '0;
    if (rx_done_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (scan_in == SC_EXT)      w_state_nx = ST_GOT_E0;
          else if (scan_in == SC_BRK) w_state_nx = ST_GOT_F0;
          else begin
            w_emit = 1'b1;
            w_ev   = {2'b00, scan_in};
          end
        end
        ST_GOT_E0: begin
          if (scan_in == SC_BRK)      w_state_nx = ST_GOT_E0F0;
          else if (scan_in != SC_EXT) begin
            w_emit     = 1'b1;
            w_ev       = {2'b10, scan_in};
            w_state_nx = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          if (!is_prefix(scan_in)) begin
            w_emit     = 1'b1;
            w_ev       = {2'b01, scan_in};
            w_state_nx = ST_IDLE;
          end
        end
        default: begin
          if (!is_prefix(scan_in)) begin
            w_emit     = 1'b1;
            w_ev       = {2'b11, scan_in};
            w_state_nx = ST_IDLE;
          end
        end
      endcase
    end else if (r_state != ST_IDLE && r_tmo_cnt == CW'(TIMEOUT - 1)) begin
      // A prefix whose follow-up byte never arrived is abandoned silently.
      w_state_nx = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 r_tmo_cnt <= '0;
    else if (rx_done_tick || r_state == ST_IDLE) r_tmo_cnt <= '0;
    else                                       r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  // Left/right keys are tracked separately so releasing one keeps the other held.
  assign w_make = ~w_ev[EV_BRK];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_lctrl  <= 1'b0;
      r_rctrl  <= 1'b0;
      r_lalt   <= 1'b0;
      r_ralt   <= 1'b0;
    end else if (w_emit) begin
      case (w_ev[7:0])
        SC_LSHIFT: r_lshift <= w_make;
        SC_RSHIFT: r_rshift <= w_make;
        SC_CTRL: begin
          if (w_ev[EV_EXT]) r_rctrl <= w_make;
          else              r_lctrl <= w_make;
        end
        SC_ALT: begin
          if (w_ev[EV_EXT]) r_ralt <= w_make;
          else              r_lalt <= w_make;
        end
        default: ;
      endcase
    end
  end

  assign shift_held = r_lshift | r_rshift;
  assign ctrl_held  = r_lctrl | r_rctrl;
  assign alt_held   = r_lalt | r_ralt;

  ps2_event_fifo #(
    .WIDTH (10),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_wr       (w_emit),
    .i_wr_data  (w_ev),
    .i_rd       (ev_rd),
    .o_rd_data  (ev_data),
    .o_empty    (ev_empty),
    .o_full     (w_full),
    .o_count    (ev_count),
    .o_overflow (overflow)
  );

  // One free slot of slack absorbs a frame the receiver had already started.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rx_en <= 1'b1;
    else       r_rx_en <= (ev_count < CNW'(DEPTH - 1));
  end

  assign rx_en = r_rx_en;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder: expected events are queued as
// bytes are driven and compared as the consumer pops the FIFO.
module tb_ps2_scan_decoder;
  import ps2_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] scan_in;
  logic       rx_en;
  logic       ev_rd;
  logic [9:0] ev_data;
  logic       ev_empty;
  logic [$clog2(DEPTH):0] ev_count;
  logic       overflow;
  logic       shift_held, ctrl_held, alt_held;
  ps2_state_t dbg_state;

  logic [9:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  ps2_scan_decoder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .scan_in      (scan_in),
    .rx_en        (rx_en),
    .ev_rd        (ev_rd),
    .ev_data      (ev_data),
    .ev_empty     (ev_empty),
    .ev_count     (ev_count),
    .overflow     (overflow),
    .shift_held   (shift_held),
    .ctrl_held    (ctrl_held),
    .alt_held     (alt_held),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with outputs settled.
  task automatic send(input logic [7:0] b);
    rx_done_tick = 1'b1;
    scan_in      = b;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic send_exp(input logic [7:0] b, input logic [9:0] ev);
    exp_q.push_back(ev);
    send(b);
  endtask

  task automatic pop_check(input string tag);
    int k = 0;
    while (ev_empty && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (ev_empty) begin
      check({tag, "_timeout"}, 32'd1, 32'd0);
    end else if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, {22'd0, ev_data}, 32'h3ff);
    end else begin
      check(tag, {22'd0, ev_data}, {22'd0, exp_q.pop_front()});
      ev_rd = 1'b1;
      @(negedge clk);
      ev_rd = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    rx_done_tick = 1'b0;
    scan_in = 8'h00;
    ev_rd = 1'b0;
    idle(3);
    reset = 1'b0;
    @(negedge clk);

    check("rst_empty", ev_empty, 1);
    check("rst_count", ev_count, 0);
    check("rst_data", ev_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_rx_en", rx_en, 1);
    check("rst_mods", {shift_held, ctrl_held, alt_held}, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // Make then break of a plain key.
    send_exp(8'h1C, 10'h01C);
    send(8'hF0);
    send_exp(8'h1C, 10'h11C);
    check("mb_count", ev_count, 2);
    check("mb_mods", {shift_held, ctrl_held, alt_held}, 0);
    pop_check("mb_ev0");
    pop_check("mb_ev1");

    // Extended release; prefixes alone must not emit.
    send(8'hE0);
    send(8'hF0);
    check("ext_noev", ev_empty, 1);
    send_exp(8'h75, 10'h375);
    check("ext_count", ev_count, 1);
    check("ext_state", dbg_state, ST_IDLE);
    pop_check("ext_ev");

    // Non-special bytes such as AA pass through as ordinary codes.
    send_exp(8'hAA, 10'h0AA);
    pop_check("aa_ev");

    // Dual Shift.
    send_exp(8'h12, 10'h012);
    check("sh_l", shift_held, 1);
    send_exp(8'h59, 10'h059);
    check("sh_lr", shift_held, 1);
    pop_check("sh_ev0");
    pop_check("sh_ev1");
    send(8'hF0);
    send_exp(8'h12, 10'h112);
    check("sh_r_only", shift_held, 1);
    send(8'hF0);
    send_exp(8'h59, 10'h159);
    check("sh_none", shift_held, 0);
    pop_check("sh_ev2");
    pop_check("sh_ev3");

    // Ctrl left/right and Alt.
    send(8'hE0);
    send_exp(8'h14, 10'h214);
    send_exp(8'h14, 10'h014);
    check("ctrl_both", ctrl_held, 1);
    pop_check("ctrl_ev0");
    pop_check("ctrl_ev1");
    send(8'hF0);
    send_exp(8'h14, 10'h114);
    check("ctrl_r_only", ctrl_held, 1);
    send(8'hE0);
    send(8'hF0);
    send_exp(8'h14, 10'h314);
    check("ctrl_none", ctrl_held, 0);
    pop_check("ctrl_ev2");
    pop_check("ctrl_ev3");
    send_exp(8'h11, 10'h011);
    check("alt_on", alt_held, 1);
    send(8'hF0);
    send_exp(8'h11, 10'h111);
    check("alt_off", alt_held, 0);
    pop_check("alt_ev0");
    pop_check("alt_ev1");

    // Prefix timeout.
    send(8'hE0);
    check("tmo_pending", dbg_state, ST_GOT_E0);
    idle(20);
    check("tmo_state", dbg_state, ST_IDLE);
    send_exp(8'h1C, 10'h01C);
    pop_check("tmo_ev");

    // Backpressure and overflow.
    send_exp(8'h1A, 10'h01A);
    send_exp(8'h1B, 10'h01B);
    send_exp(8'h21, 10'h021);
    idle(2);
    check("bp_rx_en", rx_en, 0);
    check("bp_count3", ev_count, 3);
    send_exp(8'h22, 10'h022);
    check("bp_count4", ev_count, 4);
    check("bp_no_ovf", overflow, 0);
    send(8'h23);
    check("bp_ovf", overflow, 1);
    check("bp_count_hold", ev_count, 4);
    for (int i = 0; i < 4; i++) pop_check($sformatf("bp_drain%0d", i));
    idle(2);
    check("bp_rx_en_back", rx_en, 1);
    check("bp_empty", ev_empty, 1);

    // Simultaneous read and write while full.
    send_exp(8'h2A, 10'h02A);
    send_exp(8'h2B, 10'h02B);
    send_exp(8'h2C, 10'h02C);
    send_exp(8'h2D, 10'h02D);
    check("rw_full", ev_count, 4);
    check("rw_head", {22'd0, ev_data}, {22'd0, exp_q.pop_front()});
    exp_q.push_back(10'h034);
    ev_rd = 1'b1;
    send(8'h34);
    ev_rd = 1'b0;
    check("rw_count", ev_count, 4);
    check("rw_next_head", {22'd0, ev_data}, {22'd0, exp_q[0]});
    // Shift tracks even when its event is dropped.
    send(8'h59);
    check("rw_drop_shift", shift_held, 1);
    check("rw_drop_ovf", overflow, 1);

    // Async reset with a prefix pending.
    send(8'hE0);
    check("rr_pending", dbg_state, ST_GOT_E0);
    #2 reset = 1'b1;
    #1;
    check("rr_empty", ev_empty, 1);
    check("rr_count", ev_count, 0);
    check("rr_ovf", overflow, 0);
    check("rr_shift", shift_held, 0);
    check("rr_state", dbg_state, ST_IDLE);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rr_rx_en", rx_en, 1);
    send_exp(8'h1C, 10'h01C);
    pop_check("rr_ev");

    check("final_queue", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
